// File: rtl/cs_result_buffer.sv
// Result buffer behind the CS comparator/selector. It discards the warm-up results,
// queues valid Y words in a FIFO and reports overflow and drops to the consumer.
module cs_result_buffer #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int WARMUP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] y_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              primed,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);
    localparam int WCW = $clog2(WARMUP + 1);
    localparam logic [WCW-1:0] WARM_END = WCW'(WARMUP);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic              primed_q, primed_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic full, nempty, push, pop, wr_en, drop;

    always_comb begin
        full   = (count_q == CNT_FULL);
        nempty = (count_q != '0);
        push   = cap_en & primed_q;
        pop    = nempty & out_ready;
        // A full FIFO still accepts a word when a pop frees the slot on the same edge.
        wr_en  = push & (~full | pop);
        drop   = push & full & ~pop;

        wcnt_d = wcnt_q;
        if (cap_en && (wcnt_q < WARM_END))
            wcnt_d = wcnt_q + WCW'(1);
        primed_d = (wcnt_d == WARM_END);

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q     <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wcnt_q     <= wcnt_d;
            primed_q   <= primed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; the occupancy count gates what is visible.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= y_in;
    end

    assign out_valid = nempty;
    assign out_data  = nempty ? mem[rd_ptr_q] : '0;
    assign count     = count_q;
    assign primed    = primed_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_cs_result_buffer.sv
// Scoreboard bench for cs_result_buffer: directed stimulus queues expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_cs_result_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       cap_en;
    logic [9:0] y_in;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       primed;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    cs_result_buffer dut (
        .clk(clk), .reset(reset), .cap_en(cap_en), .y_in(y_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .primed(primed), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change at posedge+1, so negedge sees exactly what the next edge will act on.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {22'd0, out_data}, 32'h0);
                checks--; errors += (out_data === 10'd0) ? 1 : 0;
            end else begin
                check("scoreboard_data", {22'd0, out_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cap_en = 1'b0; y_in = '0; out_ready = 1'b0;
        #2;
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_primed", primed, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        tick();

        // 1: warm-up with cap_en held high; 1..8 discarded, 9 is first capture
        reset = 1'b1; cap_en = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            y_in = 10'(k);
            tick();
            if (k == 7) check("warm_primed_7", primed, 0);
        end
        check("warm_primed_8", primed, 1);
        check("warm_nothing_stored", count, 0);
        y_in = 10'd9; exp_q.push_back(10'd9);
        tick();
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 10'd9);
        cap_en = 1'b0;
        tick();
        check("first_drained", out_valid, 0);
        check("empty_data_zero", out_data, 0);

        // 2: backpressure fill
        out_ready = 1'b0; cap_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y_in = 10'h100 + 10'(i); exp_q.push_back(y_in);
            tick();
        end
        cap_en = 1'b0;
        check("fill_count", count, 8);
        check("fill_valid", out_valid, 1);
        check("fill_head", out_data, 10'h100);
        check("fill_no_ovf", overflow, 0);
        tick(); tick();
        check("fill_head_stable", out_data, 10'h100);

        // 3: overflow drops three words, drain yields the original eight
        cap_en = 1'b1;
        for (int i = 8; i < 11; i++) begin
            y_in = 10'h100 + 10'(i);
            tick();
        end
        cap_en = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 3);
        check("ovf_count", count, 8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("drain_count", count, 0);
        check("drain_valid", out_valid, 0);
        check("drain_data", out_data, 0);
        out_ready = 1'b0;

        // 4: simultaneous push/pop at full with pointer wrap
        cap_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y_in = 10'h200 + 10'(i); exp_q.push_back(y_in);
            tick();
        end
        out_ready = 1'b1; y_in = 10'h3FF; exp_q.push_back(10'h3FF);
        tick();
        cap_en = 1'b0;
        check("pp_count", count, 8);
        check("pp_no_drop", drop_cnt, 3);
        for (int i = 0; i < 8; i++) tick();
        check("pp_drained", count, 0);
        check("sb_empty_mid", exp_q.size(), 0);
        out_ready = 1'b0;

        // 6: async reset with count=5 and overflow set
        cap_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            y_in = 10'h50 + 10'(i);
            tick();
        end
        cap_en = 1'b0;
        check("pre_rst_count", count, 5);
        check("pre_rst_ovf", overflow, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ovf", overflow, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_primed", primed, 0);
        exp_q.delete();
        tick();
        reset = 1'b1;

        // 5: cap_en gaps during warm-up; restarts from zero after reset
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cap_en = (i % 2 == 0);
            y_in = 10'h30 + 10'(i);
            tick();
            if (i == 13) check("gap_primed_7", primed, 0);
            if (i == 14) check("gap_primed_8", primed, 1);
        end
        check("gap_nothing_stored", count, 0);
        cap_en = 1'b1; y_in = 10'h77; exp_q.push_back(10'h77);
        tick();
        cap_en = 1'b0;
        check("gap_first_data", out_data, 10'h77);
        tick();
        check("gap_drained", out_valid, 0);
        check("sb_empty_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
